// File: rtl/and_arb_pkg.sv
// and_arb_pkg: shared FSM state encoding and requester-index width helper.
package and_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // A lone requester still needs a one-bit index.
   function automatic int rr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/and2_slice.sv
// and2_slice: WIDTH-wide bitwise AND, one bit per gate of a 74x08 package.
module and2_slice #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_a & i_b;

endmodule

// File: rtl/and2_share_arbiter.sv
// and2_share_arbiter: round-robin arbiter sharing one AND slice among N_REQ requesters.
module and2_share_arbiter
   import and_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 2,
   localparam int RR_W = rr_w(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [RR_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_y,
   output logic                   busy,
   output logic [15:0]            op_count
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [RR_W-1:0]   r_rr_ptr;
   logic [RR_W-1:0]   r_id;
   logic [RR_W-1:0]   w_win;
   logic              w_found;
   logic              w_grant;
   logic              w_done;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_y;
   logic [WIDTH-1:0]  w_and;
   logic [15:0]       r_op_count;

   // Index arithmetic stays below 2*N_REQ, so one conditional subtract wraps it.
   function automatic logic [RR_W-1:0] wrap(input int v);
      return RR_W'((v >= N_REQ) ? v - N_REQ : v);
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[wrap(int'(r_rr_ptr) + k)]) begin
            w_found = 1'b1;
            w_win   = wrap(int'(r_rr_ptr) + k);
         end
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      unique case (r_state)
         S_IDLE:  w_state_nxt = w_found ? S_EXEC : S_IDLE;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_grant = (r_state == S_IDLE) && w_found;
   assign w_done  = (r_state == S_RESP) && rsp_ready;

   and2_slice #(.WIDTH(WIDTH)) u_slice (
      .i_a (r_a),
      .i_b (r_b),
      .o_y (w_and)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_id       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_y        <= '0;
         r_op_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_a  <= req_a[w_win*WIDTH +: WIDTH];
            r_b  <= req_b[w_win*WIDTH +: WIDTH];
            r_id <= w_win;
         end
         if (r_state == S_EXEC)
            r_y <= w_and;
         if (w_done) begin
            r_rr_ptr   <= (r_id == RR_W'(N_REQ - 1)) ? '0 : r_id + RR_W'(1);
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign req_ready = w_grant ? (N_REQ'(1) << w_win) : '0;
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_id;
   assign rsp_y     = r_y;
   assign busy      = (r_state != S_IDLE);
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_and2_share_arbiter.sv
// tb_and2_share_arbiter: transaction-level model check plus directed scenarios and random traffic.
module tb_and2_share_arbiter;

   localparam int N = 4;
   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_y;
   logic           busy;
   logic [15:0]    op_count;

   int n_vec = 0;
   int n_err = 0;

   // One outstanding operation at most: owner, result, cycles since grant.
   bit          m_has = 1'b0;
   int          m_id  = 0;
   logic [W-1:0] m_y  = '0;
   int          m_age = 0;
   int          m_ptr = 0;
   logic [15:0] m_cnt = '0;

   and2_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic sample();
      int w;
      logic [N-1:0] er;
      @(negedge clk);
      w  = pick(req_valid, m_ptr);
      er = (!m_has && w >= 0) ? N'(1) << w : '0;
      chk("m_req_ready", req_ready, er);
      chk("m_busy", busy, m_has);
      chk("m_rsp_valid", rsp_valid, m_has && m_age == 2);
      chk("m_op_count", op_count, m_cnt);
      if (m_has && m_age == 2) begin
         chk("m_rsp_id", rsp_id, m_id);
         chk("m_rsp_y", rsp_y, m_y);
      end
   endtask

   task automatic tick();
      int w;
      @(posedge clk);
      if (rst) begin
         m_has = 1'b0;
         m_ptr = 0;
         m_cnt = '0;
      end else if (!m_has) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_has = 1'b1;
            m_id  = w;
            m_y   = req_a[w*W +: W] & req_b[w*W +: W];
            m_age = 1;
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (rsp_ready) begin
         m_has = 1'b0;
         m_ptr = (m_id + 1) % N;
         m_cnt = m_cnt + 16'd1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8 && busy; i++) begin
         sample();
         tick();
      end
      chk("drain_timeout", busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      sample();
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_op_count", op_count, 16'h0000);
      chk("rst_rsp_y", rsp_y, 2'b00);
      tick();

      // single op: latency and result
      req_valid = 4'b0001; req_a = 8'h02; req_b = 8'h03; rsp_ready = 1'b1;
      sample();
      chk("t33_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      sample();
      chk("t33_c1_valid", rsp_valid, 1'b0);
      tick();
      sample();
      chk("t33_rsp_valid", rsp_valid, 1'b1);
      chk("t33_rsp_id", rsp_id, 2'd0);
      chk("t33_rsp_y", rsp_y, 2'b10);
      tick();
      sample();
      chk("t33_op_count", op_count, 16'd1);
      tick();

      // all requesting: round-robin order every third cycle
      do_reset();
      req_valid = 4'hF; req_a = 8'hE4; req_b = 8'hFF; rsp_ready = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         sample();
         chk($sformatf("t34_c%0d", c), req_ready, (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000);
         tick();
      end
      drain();

      // response stall: held outputs, no grants while waiting
      req_valid = 4'b0100; req_a = 8'h10; req_b = 8'h30; rsp_ready = 1'b0;
      sample();
      chk("t35_grant", req_ready, 4'b0100);
      tick();
      req_valid = 4'hF;
      sample();
      tick();
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("t35_valid", rsp_valid, 1'b1);
         chk("t35_id", rsp_id, 2'd2);
         chk("t35_y", rsp_y, 2'b01);
         chk("t35_ready", req_ready, 4'b0000);
         tick();
      end
      req_valid = '0; rsp_ready = 1'b1;
      sample();
      chk("t35_release", rsp_valid, 1'b1);
      tick();
      drain();

      // reset in EXEC abandons the operation
      req_valid = 4'b1000; rsp_ready = 1'b1;
      sample();
      chk("t36_grant", req_ready, 4'b1000);
      tick();
      req_valid = '0; rst = 1'b1;
      sample();
      tick();
      rst = 1'b0; req_valid = 4'hF;
      sample();
      chk("t36_no_rsp", rsp_valid, 1'b0);
      chk("t36_op_count", op_count, 16'd0);
      chk("t36_from0", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      drain();

      // rr_ptr=2 then 0011: wrap to 0, then 1
      req_valid = 4'b0010;
      sample();
      chk("t38_setup", req_ready, 4'b0010);
      tick();
      drain();
      req_valid = 4'b0011;
      sample();
      chk("t38_wrap0", req_ready, 4'b0001);
      tick();
      req_valid = 4'b0010;
      sample(); tick();
      sample(); tick();
      sample();
      chk("t38_then1", req_ready, 4'b0010);
      tick();
      drain();

      // op_count wrap
      force dut.r_op_count = 16'hFFFF;
      #1;
      release dut.r_op_count;
      m_cnt = 16'hFFFF;
      req_valid = 4'b0001;
      sample();
      chk("t37_preload", op_count, 16'hFFFF);
      tick();
      drain();
      sample();
      chk("t37_wrap", op_count, 16'h0000);
      tick();

      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         req_valid = N'($urandom);
         req_a     = (N*W)'($urandom);
         req_b     = (N*W)'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         sample();
         tick();
      end
      rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
